id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS core. Captures decoded operands and control from ID.
//  Produces RS_EX/RT_EX and EX-side operands, which the EX forwarding logic and operand muxes consume.
//  Owns load-use hazard detection (bubble plus upstream stall) and the multi-cycle mult/div hold.
//  Provides register-file write-through from WB, so captured or held operands never go stale.
// PARAMETERS
//  DATA_W      32  operand/immediate width
//  REG_AW      5   register index width
//  MD_LATENCY  4   cycles a mult/div occupies EX (>=2)
// PORTS
//  clk           in   1       clock, all state on rising edge
//  rst           in   1       reset, asynchronous, active-high
//  valid_ID      in   1       ID holds a real instruction
//  RS_ID,RT_ID,RD_ID in REG_AW  source/dest indices from decode
//  usesRT_ID     in   1       instruction reads RT as a source (R-type, sw, beq)
//  readData1_ID  in   DATA_W  regfile port 1 (RS)
//  readData2_ID  in   DATA_W  regfile port 2 (RT)
//  signImm_ID    in   DATA_W  sign-extended immediate
//  ctrl_ID       in   ctrl_t  {RegWrite,MemRead,MemWrite,MemtoReg,ALUSrc,RegDst,MultDiv,ALUOp[3:0]}
//  flush_ID      in   1       kill the instruction in ID (taken branch/jump)
//  RegWrite_WB   in   1       WB stage writes the regfile
//  wrReg_WB      in   REG_AW  WB destination
//  wrData_WB     in   DATA_W  WB data
//  RS_EX,RT_EX,RD_EX out REG_AW  registered indices
//  readData1_EX,readData2_EX,signImm_EX out DATA_W  registered operands
//  ctrl_EX       out  ctrl_t  registered control
//  valid_EX      out  1       EX holds a real instruction
//  stall         out  1       freeze PC and IF/ID this cycle (combinational)
//  md_busy       out  1       EX held; EX/MEM must load a bubble (combinational)
// BEHAVIOUR
//  Reset: all _EX outputs and valid_EX = 0; FSM = RUN; counter = 0.
//  Reset takes effect immediately, including mid-operation. Outputs stall and md_busy = 0.
//  bubble = all ctrl bits 0, valid_EX 0. Index/data fields of a bubble are 0.
//  hz = valid_EX & ctrl_EX.MemRead & RT_EX!=0 & valid_ID &
//       (RT_EX==RS_ID | (usesRT_ID & RT_EX==RT_ID)).
//  WT(idx,d) = (RegWrite_WB & wrReg_WB!=0 & wrReg_WB==idx) ? wrData_WB : d.
//  FSM RUN, by priority, at each edge:
//   1. flush_ID: EX <- bubble; stall=0.
//   2. hz: EX <- bubble; stall=1 (exactly one cycle; the load reaches MEM and forwarding covers it).
//   3. else: EX <- ID fields, with readData1=WT(RS_ID,..) and readData2=WT(RT_ID,..).
//      valid_EX <- valid_ID.
//   If the incoming instr has valid_ID & ctrl_ID.MultDiv & !flush_ID & !hz:
//      next state MD_BUSY, cnt <- MD_LATENCY-1.
//  FSM MD_BUSY: stall=1, md_busy=1, all EX fields held.
//   Each cycle, held readData1_EX<=WT(RS_EX,..) and readData2_EX<=WT(RT_EX,..).
//   cnt decrements each cycle. When cnt==1, next state is RUN.
//   Total hold = MD_LATENCY-1 cycles. The instr then leaves EX on the next RUN edge.
//  hz is not evaluated in MD_BUSY.
//  flush_ID in MD_BUSY is a protocol violation: it is ignored, and the bench asserts it never occurs.
//  flush_ID and hz in the same cycle: the flush wins and stall=0.
//  Reg 0: never a hazard source and never written through.
//  Latency: ID->EX is 1 cycle. stall and md_busy are same-cycle combinational from state/inputs.
// STRUCTURE
//  mips_pkg: ctrl_t packed struct, id_ex_state_e {RUN,MD_BUSY}, REG_ZERO='0, CTRL_BUBBLE='0.
//  Sub-module hazard_detect: combinational hz from EX/ID fields. FSM, counter and regs stay in id_ex_stage.
// TESTING
//  1. EX=lw (MemRead=1,RT_EX=9), ID RS_ID=9 -> stall=1 one cycle; next EX valid=0, ctrl=0.
//     Following cycle stall=0 and the instr enters EX.
//  2. EX=lw RT_EX=0, ID RS_ID=0; and lw RT_EX=9 with ID RT_ID=9, usesRT_ID=0 -> no stall in both.
//  3. mult enters EX, MD_LATENCY=4 -> stall=md_busy=1 for 3 cycles with EX fields constant.
//     Advances on the 4th edge.
//  4. RegWrite_WB=1, wrReg_WB=5, wrData_WB=32'hDEADBEEF, RS_ID=5, readData1_ID=0
//     -> readData1_EX=32'hDEADBEEF. Same WB write to RT_EX during MD_BUSY updates readData2_EX.
//     wrReg_WB=0 -> no update.
//  5. flush_ID=1 together with hz -> EX bubble, stall=0. flush_ID alone with a valid mult in ID
//     -> bubble, FSM stays RUN.
//  6. rst asserted mid MD_BUSY (cnt=2) -> outputs 0 without a clock edge; after release,
//     RUN and no stall.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared types for the MIPS pipeline: the decoded control word, the ID/EX
// hold FSM state type and the bubble/zero-register constants.
package mips_pkg;

   typedef struct packed {
      logic       RegWrite;
      logic       MemRead;
      logic       MemWrite;
      logic       MemtoReg;
      logic       ALUSrc;
      logic       RegDst;
      logic       MultDiv;
      logic [3:0] ALUOp;
   } ctrl_t;

   typedef enum logic {
      RUN     = 1'b0,
      MD_BUSY = 1'b1
   } id_ex_state_e;

   localparam logic [4:0] REG_ZERO    = '0;
   localparam ctrl_t      CTRL_BUBBLE = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the register
// a load currently in EX is about to produce.
module hazard_detect
   import mips_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic              valid_EX,
   input  ctrl_t             ctrl_EX,
   input  logic [REG_AW-1:0] RT_EX,
   input  logic              valid_ID,
   input  logic              usesRT_ID,
   input  logic [REG_AW-1:0] RS_ID,
   input  logic [REG_AW-1:0] RT_ID,
   output logic              hz
);

   logic rt_match;

   assign rt_match = (RT_EX == RS_ID) || (usesRT_ID && (RT_EX == RT_ID));

   // A load into $zero produces nothing, so it can never be a hazard source.
   assign hz = valid_EX && ctrl_EX.MemRead && (RT_EX != REG_AW'(REG_ZERO)) &&
               valid_ID && rt_match;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: load-use bubble/stall, multi-cycle mult/div hold
// and write-through of WB results into captured or held operands.
module id_ex_stage
   import mips_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int MD_LATENCY = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid_ID,
   input  logic [REG_AW-1:0] RS_ID,
   input  logic [REG_AW-1:0] RT_ID,
   input  logic [REG_AW-1:0] RD_ID,
   input  logic              usesRT_ID,
   input  logic [DATA_W-1:0] readData1_ID,
   input  logic [DATA_W-1:0] readData2_ID,
   input  logic [DATA_W-1:0] signImm_ID,
   input  ctrl_t             ctrl_ID,
   input  logic              flush_ID,
   input  logic              RegWrite_WB,
   input  logic [REG_AW-1:0] wrReg_WB,
   input  logic [DATA_W-1:0] wrData_WB,
   output logic [REG_AW-1:0] RS_EX,
   output logic [REG_AW-1:0] RT_EX,
   output logic [REG_AW-1:0] RD_EX,
   output logic [DATA_W-1:0] readData1_EX,
   output logic [DATA_W-1:0] readData2_EX,
   output logic [DATA_W-1:0] signImm_EX,
   output ctrl_t             ctrl_EX,
   output logic              valid_EX,
   output logic              stall,
   output logic              md_busy
);

   localparam int              CNT_W    = $clog2(MD_LATENCY);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MD_LATENCY - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   id_ex_state_e      state, state_nxt;
   logic [CNT_W-1:0]  cnt, cnt_nxt;
   logic              hz;

   logic [REG_AW-1:0] rs_nxt, rt_nxt, rd_nxt;
   logic [DATA_W-1:0] rd1_nxt, rd2_nxt, imm_nxt;
   ctrl_t             ctrl_nxt;
   logic              valid_nxt;

   // Register-file write-through; $zero is never overwritten.
   function automatic logic [DATA_W-1:0] wt(input logic [REG_AW-1:0] idx,
                                            input logic [DATA_W-1:0] d);
      return (RegWrite_WB && (wrReg_WB != REG_AW'(REG_ZERO)) && (wrReg_WB == idx))
             ? wrData_WB : d;
   endfunction

   hazard_detect #(.REG_AW(REG_AW)) u_hazard_detect (
      .valid_EX  (valid_EX),
      .ctrl_EX   (ctrl_EX),
      .RT_EX     (RT_EX),
      .valid_ID  (valid_ID),
      .usesRT_ID (usesRT_ID),
      .RS_ID     (RS_ID),
      .RT_ID     (RT_ID),
      .hz        (hz)
   );

   always_comb begin
      // NOTE: every signal gets a default first so no path can infer a latch.
      state_nxt = state;
      cnt_nxt   = cnt;
      stall     = 1'b0;
      md_busy   = 1'b0;
      rs_nxt    = RS_EX;
      rt_nxt    = RT_EX;
      rd_nxt    = RD_EX;
      rd1_nxt   = readData1_EX;
      rd2_nxt   = readData2_EX;
      imm_nxt   = signImm_EX;
      ctrl_nxt  = ctrl_EX;
      valid_nxt = valid_EX;

      unique case (state)
         RUN: begin
            if (flush_ID || hz) begin
               rs_nxt    = '0;
               rt_nxt    = '0;
               rd_nxt    = '0;
               rd1_nxt   = '0;
               rd2_nxt   = '0;
               imm_nxt   = '0;
               ctrl_nxt  = CTRL_BUBBLE;
               valid_nxt = 1'b0;
               stall     = !flush_ID;
            end else begin
               rs_nxt    = RS_ID;
               rt_nxt    = RT_ID;
               rd_nxt    = RD_ID;
               rd1_nxt   = wt(RS_ID, readData1_ID);
               rd2_nxt   = wt(RT_ID, readData2_ID);
               imm_nxt   = signImm_ID;
               ctrl_nxt  = ctrl_ID;
               valid_nxt = valid_ID;
               if (valid_ID && ctrl_ID.MultDiv) begin
                  state_nxt = MD_BUSY;
                  cnt_nxt   = CNT_LOAD;
               end
            end
         end
         MD_BUSY: begin
            // Held operands keep absorbing WB results so they are current on exit.
            stall   = 1'b1;
            md_busy = 1'b1;
            rd1_nxt = wt(RS_EX, readData1_EX);
            rd2_nxt = wt(RT_EX, readData2_EX);
            cnt_nxt = cnt - CNT_LAST;
            if (cnt == CNT_LAST) state_nxt = RUN;
         end
         default: state_nxt = RUN;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers
   // update together from pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= RUN;
         cnt          <= '0;
         RS_EX        <= '0;
         RT_EX        <= '0;
         RD_EX        <= '0;
         readData1_EX <= '0;
         readData2_EX <= '0;
         signImm_EX   <= '0;
         ctrl_EX      <= CTRL_BUBBLE;
         valid_EX     <= 1'b0;
      end else begin
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         RS_EX        <= rs_nxt;
         RT_EX        <= rt_nxt;
         RD_EX        <= rd_nxt;
         readData1_EX <= rd1_nxt;
         readData2_EX <= rd2_nxt;
         signImm_EX   <= imm_nxt;
         ctrl_EX      <= ctrl_nxt;
         valid_EX     <= valid_nxt;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a transaction-level model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_id_ex_stage;
   import mips_pkg::*;

   localparam int DATA_W     = 32;
   localparam int REG_AW     = 5;
   localparam int MD_LATENCY = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              valid_ID;
   logic [REG_AW-1:0] RS_ID, RT_ID, RD_ID;
   logic              usesRT_ID;
   logic [DATA_W-1:0] readData1_ID, readData2_ID, signImm_ID;
   ctrl_t             ctrl_ID;
   logic              flush_ID;
   logic              RegWrite_WB;
   logic [REG_AW-1:0] wrReg_WB;
   logic [DATA_W-1:0] wrData_WB;
   logic [REG_AW-1:0] RS_EX, RT_EX, RD_EX;
   logic [DATA_W-1:0] readData1_EX, readData2_EX, signImm_EX;
   ctrl_t             ctrl_EX;
   logic              valid_EX, stall, md_busy;

   int total = 0;
   int bad   = 0;

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MD_LATENCY(MD_LATENCY)) dut (
      .clk(clk), .rst(rst), .valid_ID(valid_ID), .RS_ID(RS_ID), .RT_ID(RT_ID),
      .RD_ID(RD_ID), .usesRT_ID(usesRT_ID), .readData1_ID(readData1_ID),
      .readData2_ID(readData2_ID), .signImm_ID(signImm_ID), .ctrl_ID(ctrl_ID),
      .flush_ID(flush_ID), .RegWrite_WB(RegWrite_WB), .wrReg_WB(wrReg_WB),
      .wrData_WB(wrData_WB), .RS_EX(RS_EX), .RT_EX(RT_EX), .RD_EX(RD_EX),
      .readData1_EX(readData1_EX), .readData2_EX(readData2_EX),
      .signImm_EX(signImm_EX), .ctrl_EX(ctrl_EX), .valid_EX(valid_EX),
      .stall(stall), .md_busy(md_busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, wanted %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // The EX slot holds one instruction record; 'hold' counts remaining
   // mult/div occupancy cycles during which the record stays put.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rs, rt, rd;
      logic [DATA_W-1:0] d1, d2, imm;
      ctrl_t             ctrl;
      logic [7:0]        hold;
   } model_t;

   model_t m;

   function automatic logic [DATA_W-1:0] latest(input logic [REG_AW-1:0] r,
                                                input logic [DATA_W-1:0] d);
      if (RegWrite_WB && wrReg_WB != 0 && wrReg_WB == r) return wrData_WB;
      return d;
   endfunction

   function automatic logic model_hz(input model_t s);
      return s.valid && s.ctrl.MemRead && s.rt != 0 && valid_ID &&
             (s.rt == RS_ID || (usesRT_ID && s.rt == RT_ID));
   endfunction

   function automatic model_t model_step(input model_t s);
      model_t n;
      n = s;
      if (s.hold != 0) begin
         n.d1   = latest(s.rs, s.d1);
         n.d2   = latest(s.rt, s.d2);
         n.hold = s.hold - 8'd1;
      end else if (flush_ID || model_hz(s)) begin
         n = '0;
      end else begin
         n.valid = valid_ID;
         n.rs    = RS_ID;
         n.rt    = RT_ID;
         n.rd    = RD_ID;
         n.d1    = latest(RS_ID, readData1_ID);
         n.d2    = latest(RT_ID, readData2_ID);
         n.imm   = signImm_ID;
         n.ctrl  = ctrl_ID;
         n.hold  = (valid_ID && ctrl_ID.MultDiv) ? 8'(MD_LATENCY - 1) : 8'd0;
      end
      return n;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) m <= '0;
      else     m <= model_step(m);
   end

   // Single compare process, every cycle on the falling edge.
   always @(negedge clk) begin
      check("valid_EX", 32'(valid_EX), 32'(m.valid));
      check("RS_EX", 32'(RS_EX), 32'(m.rs));
      check("RT_EX", 32'(RT_EX), 32'(m.rt));
      check("RD_EX", 32'(RD_EX), 32'(m.rd));
      check("readData1_EX", readData1_EX, m.d1);
      check("readData2_EX", readData2_EX, m.d2);
      check("signImm_EX", signImm_EX, m.imm);
      check("ctrl_EX", 32'(ctrl_EX), 32'(m.ctrl));
      check("md_busy", 32'(md_busy), 32'(m.hold != 0));
      check("stall", 32'(stall), 32'((m.hold != 0) || (model_hz(m) && !flush_ID)));
      if (md_busy) check("no_flush_in_busy", 32'(flush_ID), 32'd0);
   end

   // ---------------- stimulus ----------------
   function automatic ctrl_t mk(input logic rw, input logic mr, input logic md,
                                input logic [3:0] op);
      ctrl_t c;
      c = '0;
      c.RegWrite = rw;
      c.MemRead  = mr;
      c.MemtoReg = mr;
      c.ALUSrc   = mr;
      c.MultDiv  = md;
      c.ALUOp    = op;
      return c;
   endfunction

   task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urt, input logic [31:0] d1,
                         input logic [31:0] d2, input logic [31:0] imm, input ctrl_t c);
      valid_ID = v; RS_ID = rs; RT_ID = rt; RD_ID = rd; usesRT_ID = urt;
      readData1_ID = d1; readData2_ID = d2; signImm_ID = imm; ctrl_ID = c;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      flush_ID = 1'b0; RegWrite_WB = 1'b0; wrReg_WB = '0; wrData_WB = '0;
      set_id(0, 0, 0, 0, 0, 0, 0, 0, '0);
      step(); step();
      check("reset valid_EX", 32'(valid_EX), 32'd0);
      check("reset ctrl_EX", 32'(ctrl_EX), 32'd0);
      check("reset stall", 32'(stall), 32'd0);
      rst = 1'b0;
      step();

      // Load-use on RS: one bubble, then the consumer enters.
      set_id(1, 1, 9, 0, 0, 32'd100, 32'd0, 32'd4, mk(1, 1, 0, 4'd0));
      step();
      check("lw RT_EX", 32'(RT_EX), 32'd9);
      set_id(1, 9, 2, 3, 1, 32'h11, 32'h22, 32'd0, mk(1, 0, 0, 4'd2));
      #1 check("hz stall", 32'(stall), 32'd1);
      step();
      check("bubble valid", 32'(valid_EX), 32'd0);
      check("bubble ctrl", 32'(ctrl_EX), 32'd0);
      check("post-bubble stall", 32'(stall), 32'd0);
      step();
      check("consumer RS_EX", 32'(RS_EX), 32'd9);
      check("consumer RD_EX", 32'(RD_EX), 32'd3);

      // Load into $zero, and RT match when RT is not a source: no stall.
      set_id(1, 0, 0, 0, 0, 0, 0, 32'd8, mk(1, 1, 0, 4'd0));
      step();
      set_id(1, 0, 4, 6, 1, 0, 32'h44, 0, mk(1, 0, 0, 4'd2));
      #1 check("lw r0 no stall", 32'(stall), 32'd0);
      step();
      set_id(1, 1, 9, 0, 0, 32'd5, 0, 32'd12, mk(1, 1, 0, 4'd0));
      step();
      set_id(1, 2, 9, 0, 0, 32'd7, 32'd3, 32'd1, mk(1, 0, 0, 4'd0));
      #1 check("usesRT=0 no stall", 32'(stall), 32'd0);
      step();

      // WB write-through into a captured operand; $zero is never written through.
      RegWrite_WB = 1; wrReg_WB = 5; wrData_WB = 32'hDEADBEEF;
      set_id(1, 5, 1, 2, 1, 32'd0, 32'd9, 0, mk(1, 0, 0, 4'd2));
      step();
      check("WT readData1", readData1_EX, 32'hDEADBEEF);
      wrReg_WB = 0;
      set_id(1, 0, 1, 2, 1, 32'h11, 32'd9, 0, mk(1, 0, 0, 4'd2));
      step();
      check("WT r0 ignored", readData1_EX, 32'h11);
      RegWrite_WB = 0;

      // Mult/div hold: 3 busy cycles, fields frozen, WB into held RT.
      set_id(1, 6, 7, 0, 1, 32'd3, 32'd4, 0, mk(0, 0, 1, 4'd8));
      step();
      set_id(1, 1, 2, 8, 1, 32'd1, 32'd2, 0, mk(1, 0, 0, 4'd2));
      for (int i = 0; i < MD_LATENCY - 1; i++) begin
         #1 check("md stall", 32'(stall), 32'd1);
         check("md_busy", 32'(md_busy), 32'd1);
         if (i == 1) begin
            RegWrite_WB = 1; wrReg_WB = 7; wrData_WB = 32'hCAFE0007;
         end
         step();
         RegWrite_WB = 0;
         check("md hold RS_EX", 32'(RS_EX), 32'd6);
      end
      check("md held WT rd2", readData2_EX, 32'hCAFE0007);
      check("md released", 32'(md_busy), 32'd0);
      step();
      check("after md RD_EX", 32'(RD_EX), 32'd8);

      // Flush beats hazard; flushed mult does not start a hold.
      set_id(1, 1, 9, 0, 0, 0, 0, 0, mk(1, 1, 0, 4'd0));
      step();
      set_id(1, 9, 3, 4, 1, 0, 0, 0, mk(1, 0, 0, 4'd2));
      flush_ID = 1;
      #1 check("flush+hz stall", 32'(stall), 32'd0);
      step();
      check("flush bubble valid", 32'(valid_EX), 32'd0);
      set_id(1, 6, 7, 0, 1, 32'd3, 32'd4, 0, mk(0, 0, 1, 4'd8));
      step();
      check("flushed mult no busy", 32'(md_busy), 32'd0);
      check("flushed mult ctrl", 32'(ctrl_EX), 32'd0);
      flush_ID = 0;

      // Asynchronous reset in the middle of a hold (cnt=2).
      step();
      step();
      #2 rst = 1;
      #1 check("async rst valid", 32'(valid_EX), 32'd0);
      check("async rst md_busy", 32'(md_busy), 32'd0);
      check("async rst rd1", readData1_EX, 32'd0);
      set_id(0, 0, 0, 0, 0, 0, 0, 0, '0);
      step();
      rst = 0;
      step();
      check("post-rst md_busy", 32'(md_busy), 32'd0);
      check("post-rst stall", 32'(stall), 32'd0);
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
